bytes2bits_stream: RTL and testbench

Streaming byte-to-bit-word unpacker: accepts one byte per handshake and emits OUT_W-bit words taken LSB-first from the concatenated byte stream. Bit 0 of the first byte is bit 0 of the first word. This is the inverse direction of the bits-to-bytes packing path. It feeds ByteDecode_d-style consumers: d-bit coefficient extraction from encoded key and ciphertext byte streams.

---
 rtl/bytes2bits_stream.sv | 97 +++++++++
 tb/tb_bytes2bits_stream.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bytes2bits_stream.sv
`default_nettype none
// ============================================================================
//  Module   : bytes2bits_stream
//  Purpose  : Streaming byte-to-word unpacker. Bytes enter one per handshake
//             and leave as OUT_W-bit words taken LSB-first from the stream.
//  Revision : 1.0 - initial release
// ============================================================================
module bytes2bits_stream #(
    parameter int OUT_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_byte_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_last_o
);

    localparam int BUF_W = OUT_W + 8;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] C_OUT_W = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] C_BYTE  = CNT_W'(8);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drain_q;
    logic             drain_d;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_out_last;
    logic             w_in_accept;
    logic             w_out_accept;
    logic [BUF_W-1:0] w_shift_buf;
    logic [CNT_W-1:0] w_shift_cnt;

    // Status is derived from registered state only, so no input reaches an
    // output combinationally.
    always_comb begin
        w_in_ready   = !drain_q && (cnt_q <= C_OUT_W);
        w_out_valid  = (cnt_q >= C_OUT_W) || (drain_q && (cnt_q != '0));
        w_out_last   = drain_q && (cnt_q <= C_OUT_W) && w_out_valid;
        w_in_accept  = in_valid_i && w_in_ready;
        w_out_accept = w_out_valid && out_ready_i;
    end

    always_comb begin
        w_shift_buf = buf_q;
        w_shift_cnt = cnt_q;
        if (w_out_accept) begin
            w_shift_buf = buf_q >> OUT_W;
            w_shift_cnt = (cnt_q >= C_OUT_W) ? (cnt_q - C_OUT_W) : '0;
        end

        buf_d   = w_shift_buf;
        cnt_d   = w_shift_cnt;
        drain_d = drain_q;

        // The new byte lands directly above the bits that survive the shift.
        if (w_in_accept) begin
            buf_d = w_shift_buf | (BUF_W'(in_byte_i) << w_shift_cnt);
            cnt_d = w_shift_cnt + C_BYTE;
            if (in_last_i) begin
                drain_d = 1'b1;
            end
        end

        if (w_out_accept && w_out_last) begin
            drain_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_last_o  = w_out_last;
    assign out_data_o  = buf_q[OUT_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_bytes2bits_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bytes2bits_stream
//  Purpose  : Self-checking bench for bytes2bits_stream over several widths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bytes2bits_stream;

    localparam int NI  = 7;
    localparam int K1  = 0;
    localparam int K12 = 5;

    function automatic int w_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            3:       return 10;
            4:       return 11;
            5:       return 12;
            default: return 16;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_last;
    logic [NI-1:0] out_ready;
    wire  [NI-1:0] in_ready;
    wire  [NI-1:0] out_valid;
    wire  [NI-1:0] out_last;
    logic [7:0]    in_byte [NI];
    wire  [15:0]   out_data [NI];

    int checks = 0;
    int errors = 0;

    logic [7:0]  tb_bytes[$];
    bit          tb_lasts[$];
    logic [15:0] got_data[$];
    bit          got_last[$];
    logic [15:0] exp_data[$];
    bit          exp_last[$];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int W = w_of(g);
            wire [W-1:0] data_w;
            bytes2bits_stream #(.OUT_W(W)) u_dut (
                .clk_i      (clk),
                .rst_i      (rst),
                .in_valid_i (in_valid[g]),
                .in_ready_o (in_ready[g]),
                .in_byte_i  (in_byte[g]),
                .in_last_i  (in_last[g]),
                .out_valid_o(out_valid[g]),
                .out_ready_i(out_ready[g]),
                .out_data_o (data_w),
                .out_last_o (out_last[g])
            );
            assign out_data[g] = 16'(data_w);
        end
    endgenerate

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives tb_bytes/tb_lasts into instance k from index 'start' and collects
    // accepted output beats until every message has produced its last word.
    task automatic run(input int k, input int start, input bit throttle, input int budget);
        int idx  = start;
        int nmsg = 0;
        int seen = 0;
        int cyc  = 0;
        for (int i = start; i < tb_lasts.size(); i++) if (tb_lasts[i]) nmsg++;
        got_data.delete();
        got_last.delete();
        while (seen < nmsg && cyc < budget) begin
            in_valid[k]  = (idx < tb_bytes.size()) && (!throttle || $urandom_range(0, 3) != 0);
            in_byte[k]   = (idx < tb_bytes.size()) ? tb_bytes[idx] : 8'($urandom);
            in_last[k]   = (idx < tb_bytes.size()) ? tb_lasts[idx] : 1'b0;
            out_ready[k] = !throttle || ($urandom_range(0, 2) != 0);
            if (out_valid[k] && out_ready[k]) begin
                got_data.push_back(out_data[k]);
                got_last.push_back(out_last[k]);
                if (out_last[k]) seen++;
            end
            if (in_valid[k] && in_ready[k]) idx++;
            step();
            cyc++;
        end
        in_valid[k]  = 1'b0;
        in_last[k]   = 1'b0;
        out_ready[k] = 1'b0;
        if (seen < nmsg) begin
            checks++;
            errors++;
            $display("FAIL run_timeout inst %0d: last beats %0d, required %0d", k, seen, nmsg);
        end
    endtask

    // Reference unpack: every message is its own little-endian bit string,
    // cut into w-bit words with the final word zero-padded.
    task automatic build_expected(input int w);
        logic [7:0] msg[$];
        exp_data.delete();
        exp_last.delete();
        foreach (tb_bytes[i]) begin
            msg.push_back(tb_bytes[i]);
            if (tb_lasts[i]) begin
                int nbits = 8 * msg.size();
                int nw    = (nbits + w - 1) / w;
                for (int j = 0; j < nw; j++) begin
                    logic [15:0] v = '0;
                    for (int b = 0; b < w; b++) begin
                        int p = j * w + b;
                        if (p < nbits) v[b] = msg[p / 8][p % 8];
                    end
                    exp_data.push_back(v);
                    exp_last.push_back(j == nw - 1);
                end
                msg.delete();
            end
        end
    endtask

    task automatic load(input logic [7:0] b[$]);
        tb_bytes = b;
        tb_lasts.delete();
        foreach (b[i]) tb_lasts.push_back(i == b.size() - 1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 ||
                out_data[k] !== 16'h0 || out_last[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst %0d: rdy %b vld %b data %h last %b, required 1 0 0000 0",
                         k, in_ready[k], out_valid[k], out_data[k], out_last[k]);
            end
        end
    endtask

    task automatic test_aligned();
        load('{8'h01, 8'h23, 8'h45});
        run(K12, 0, 1'b0, 100);
        checks++;
        if (got_data.size() !== 2) begin
            errors++;
            $display("FAIL aligned_count: got %0d words, required 2", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 16'h301 || got_last[0] !== 1'b0) begin
                errors++;
                $display("FAIL aligned_w0: got %h/%b, required 0301/0", got_data[0], got_last[0]);
            end
            checks++;
            if (got_data[1] !== 16'h452 || got_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL aligned_w1: got %h/%b, required 0452/1", got_data[1], got_last[1]);
            end
        end
    endtask

    task automatic test_padded();
        out_ready[K12] = 1'b0;
        in_valid[K12]  = 1'b1;
        in_byte[K12]   = 8'h01;
        in_last[K12]   = 1'b0;
        step();
        in_byte[K12]   = 8'h23;
        in_last[K12]   = 1'b1;
        step();
        in_valid[K12]  = 1'b0;
        in_last[K12]   = 1'b0;
        checks++;
        if (in_ready[K12] !== 1'b0 || out_valid[K12] !== 1'b1 ||
            out_data[K12] !== 16'h301 || out_last[K12] !== 1'b0) begin
            errors++;
            $display("FAIL padded_w0: rdy %b vld %b data %h last %b, required 0 1 0301 0",
                     in_ready[K12], out_valid[K12], out_data[K12], out_last[K12]);
        end
        out_ready[K12] = 1'b1;
        step();
        checks++;
        if (in_ready[K12] !== 1'b0 || out_valid[K12] !== 1'b1 ||
            out_data[K12] !== 16'h002 || out_last[K12] !== 1'b1) begin
            errors++;
            $display("FAIL padded_w1: rdy %b vld %b data %h last %b, required 0 1 0002 1",
                     in_ready[K12], out_valid[K12], out_data[K12], out_last[K12]);
        end
        step();
        out_ready[K12] = 1'b0;
        checks++;
        if (in_ready[K12] !== 1'b1 || out_valid[K12] !== 1'b0) begin
            errors++;
            $display("FAIL padded_done: rdy %b vld %b, required 1 0", in_ready[K12], out_valid[K12]);
        end
    endtask

    task automatic test_w1();
        logic [7:0] ref_bits = 8'hA5;
        load('{8'hA5});
        run(K1, 0, 1'b0, 100);
        checks++;
        if (got_data.size() !== 8) begin
            errors++;
            $display("FAIL w1_count: got %0d words, required 8", got_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_data[i] !== 16'(ref_bits[i]) || got_last[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL w1_bit%0d: got %h/%b, required %h/%b",
                             i, got_data[i], got_last[i], ref_bits[i], i == 7);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int bad = 0;
        load('{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB});
        build_expected(12);
        for (int c = 0; c < 10; c++) begin
            in_valid[K12]  = 1'b1;
            in_byte[K12]   = tb_bytes[idx];
            in_last[K12]   = tb_lasts[idx];
            out_ready[K12] = 1'b0;
            if (c == 1) begin
                checks++;
                if (in_ready[K12] !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_ready_cnt8: got %b, required 1", in_ready[K12]);
                end
            end
            if (in_ready[K12]) idx++;
            step();
            if (c >= 1 && (in_ready[K12] !== 1'b0 || out_valid[K12] !== 1'b1 ||
                           out_data[K12] !== 16'h301 || out_last[K12] !== 1'b0)) bad++;
        end
        in_valid[K12] = 1'b0;
        checks++;
        if (idx !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: accepted %0d bytes, %0d unstable cycles, required 2 and 0", idx, bad);
        end
        run(K12, idx, 1'b0, 100);
        checks++;
        if (got_data !== exp_data || got_last !== exp_last) begin
            errors++;
            $display("FAIL bp_release: got %0d words first %h, required %0d words first %h",
                     got_data.size(), got_data.size() ? got_data[0] : 16'hx,
                     exp_data.size(), exp_data[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < NI; k++) begin
            int shown = 0;
            int nlast = 0;
            tb_bytes.delete();
            tb_lasts.delete();
            for (int m = 0; m < 3; m++) begin
                for (int i = 0; i < 384; i++) begin
                    tb_bytes.push_back(8'($urandom));
                    tb_lasts.push_back(i == 383);
                end
            end
            build_expected(w_of(k));
            run(k, 0, 1'b1, 25000);
            checks++;
            if (got_data.size() !== exp_data.size()) begin
                errors++;
                $display("FAIL rand_count W=%0d: got %0d words, required %0d",
                         w_of(k), got_data.size(), exp_data.size());
            end
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                    errors++;
                    if (shown < 4) begin
                        shown++;
                        $display("FAIL rand_word W=%0d #%0d: got %h/%b, required %h/%b",
                                 w_of(k), i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
                    end
                end
            end
            foreach (got_last[i]) if (got_last[i]) nlast++;
            checks++;
            if (nlast !== 3) begin
                errors++;
                $display("FAIL rand_lasts W=%0d: got %0d, required 3", w_of(k), nlast);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready[K12] = 1'b0;
        in_valid[K12]  = 1'b1;
        in_last[K12]   = 1'b0;
        in_byte[K12]   = 8'h01;
        step();
        in_byte[K12]   = 8'h23;
        step();
        in_valid[K12]  = 1'b0;
        checks++;
        if (out_valid[K12] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: vld %b, required 1", out_valid[K12]);
        end
        rst = 1'b1;
        out_ready[K12] = 1'b1;
        step();
        out_ready[K12] = 1'b0;
        checks++;
        if (in_ready[K12] !== 1'b1 || out_valid[K12] !== 1'b0 ||
            out_data[K12] !== 16'h0 || out_last[K12] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post: rdy %b vld %b data %h last %b, required 1 0 0000 0",
                     in_ready[K12], out_valid[K12], out_data[K12], out_last[K12]);
        end
        rst = 1'b0;
        load('{8'hFF, 8'h0F});
        run(K12, 0, 1'b0, 100);
        checks++;
        if (got_data.size() !== 2 || got_data[0] !== 16'hFFF || got_last[0] !== 1'b0 ||
            got_data[1] !== 16'h000 || got_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fresh: got %0d words %h %h, required 2 words 0fff 0000(last)",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 16'hx,
                     got_data.size() > 1 ? got_data[1] : 16'hx);
        end
    endtask

    initial begin
        in_valid  = '0;
        in_last   = '0;
        out_ready = '0;
        for (int k = 0; k < NI; k++) in_byte[k] = 8'h00;
        rst = 1'b1;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_aligned();
        test_padded();
        test_w1();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
